uncache_axi_unit: RTL and testbench

UNCACHE_AXI_UNIT -- requirements
Module: uncache_axi_unit

---
 rtl/uncache_axi_unit.sv | 200 ++++++++++++++++++++
 tb/tb_uncache_axi_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uncache_axi_unit.sv
// uncache_axi_unit: bridges single uncached CPU accesses onto an AXI master
// port, keeping one transaction outstanding at a time.
// Reads use AR then R. Writes use AW and W in parallel, then B.
// The AXI fields not brought out here are tied by the surrounding wrapper:
// id=0, len=0, burst=INCR, lock/cache/prot=0, wlast=1.
// Optional feature macro: UNCACHE_WBUF_EN. When it is defined, a write
// reports data_ok in the cycle after it is accepted. The unit still refuses
// new requests until bvalid retires the write.
module uncache_axi_unit (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] axi_rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_AR = 3'd1,
      S_RD_R  = 3'd2,
      S_WR_AW = 3'd3,
      S_WR_B  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        accept_s;
   logic        aw_fire_s;
   logic        w_fire_s;
   logic [1:0]  size_r;
   logic [31:0] addr_r;
   logic [3:0]  wstrb_r;
   logic [31:0] wdata_r;
   logic [31:0] rdata_r;
   logic        aw_done_r;
   logic        w_done_r;
`ifdef UNCACHE_WBUF_EN
   logic        wbuf_ok_r;
`endif

   // Next-state decode and per-channel write handshake detection.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      aw_fire_s = 1'b0;
      w_fire_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req) begin
               accept_s = 1'b1;
               state_s  = wr ? S_WR_AW : S_RD_AR;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RD_AR: begin
            if (arready) begin
               state_s = S_RD_R;
            end else begin
               state_s = S_RD_AR;
            end
         end
         S_RD_R: begin
            if (rvalid) begin
               state_s = S_RESP;
            end else begin
               state_s = S_RD_R;
            end
         end
         S_WR_AW: begin
            aw_fire_s = ~aw_done_r & awready;
            w_fire_s  = ~w_done_r & wready;
            if ((aw_done_r | aw_fire_s) & (w_done_r | w_fire_s)) begin
               state_s = S_WR_B;
            end else begin
               state_s = S_WR_AW;
            end
         end
         S_WR_B: begin
            if (bvalid) begin
`ifdef UNCACHE_WBUF_EN
               state_s = S_IDLE;
`else
               state_s = S_RESP;
`endif
            end else begin
               state_s = S_WR_B;
            end
         end
         S_RESP: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State register. Reset aborts any in-flight transaction.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request capture. The payload stays stable on the AXI side until its handshake completes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         size_r  <= 2'd0;
         addr_r  <= 32'd0;
         wstrb_r <= 4'd0;
         wdata_r <= 32'd0;
      end else if (accept_s) begin
         size_r  <= size;
         addr_r  <= addr;
         wstrb_r <= wr ? wstrb : 4'd0;
         wdata_r <= wr ? wdata : 32'd0;
      end
   end

   // AW/W completion flags let the two channels finish in either order.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else if (accept_s) begin
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else begin
         aw_done_r <= aw_done_r | aw_fire_s;
         w_done_r  <= w_done_r | w_fire_s;
      end
   end

   // Read data holding register. Only a completed read updates it.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rdata_r <= 32'd0;
      end else if ((state_r == S_RD_R) && rvalid) begin
         rdata_r <= axi_rdata;
      end
   end

`ifdef UNCACHE_WBUF_EN
   // Early write completion: pulse once, in the cycle after a write is accepted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wbuf_ok_r <= 1'b0;
      end else begin
         wbuf_ok_r <= accept_s & wr;
      end
   end

   assign data_ok = (state_r == S_RESP) | wbuf_ok_r;
`else
   assign data_ok = (state_r == S_RESP);
`endif

   // aresetn is included so that addr_ok reads 0 while reset is held.
   assign addr_ok   = aresetn & (state_r == S_IDLE);
   assign rdata     = rdata_r;
   assign araddr    = addr_r;
   assign arsize    = {1'b0, size_r};
   assign arvalid   = (state_r == S_RD_AR);
   assign rready    = (state_r == S_RD_R);
   assign awaddr    = addr_r;
   assign awsize    = {1'b0, size_r};
   assign awvalid   = (state_r == S_WR_AW) & ~aw_done_r;
   assign axi_wdata = wdata_r;
   assign axi_wstrb = wstrb_r;
   assign wvalid    = (state_r == S_WR_AW) & ~w_done_r;
   assign bready    = (state_r == S_WR_B);

endmodule

// File: tb/tb_uncache_axi_unit.sv
// Testbench for uncache_axi_unit.
// A table of transactions is run against a sequential AXI slave model.
// Completions are checked against a scoreboard queue for rdata and cycle.
module tb_uncache_axi_unit;

   logic        aclk = 1'b0;
   logic        aresetn, req, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata, araddr, axi_rdata, awaddr, axi_wdata;
   logic [3:0]  wstrb, axi_wstrb;
   logic        addr_ok, data_ok, arvalid, arready, rvalid, rready;
   logic [2:0]  arsize, awsize;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;

   uncache_axi_unit dut (
      .aclk(aclk), .aresetn(aresetn), .req(req), .wr(wr), .size(size),
      .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok),
      .data_ok(data_ok), .rdata(rdata), .araddr(araddr), .arsize(arsize),
      .arvalid(arvalid), .arready(arready), .axi_rdata(axi_rdata),
      .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awsize(awsize),
      .awvalid(awvalid), .awready(awready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;     // write data, or the R data the slave returns
      int          d0;       // arready delay (read) / awready delay (write)
      int          d1;       // rvalid delay (read)  / wready delay (write)
      int          d2;       // bvalid delay (write)
      logic [2:0]  exp_axsize;
      int          exp_lat;  // cycles from accept to data_ok
   } vec_t;

   typedef struct {
      logic [31:0] exp_rdata;
      int          due;
   } sb_t;

   sb_t         sb[$];
   sb_t         mon_e;
   vec_t        vt[6];
   int          total = 0;
   int          bad = 0;
   logic [31:0] model_rdata = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   // Completion monitor: every data_ok must match the oldest expectation.
   always @(negedge aclk) begin
      if (aresetn === 1'b1 && data_ok === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_data_ok at cycle %0d: got 1 want 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("rdata", rdata, mon_e.exp_rdata);
            chk("data_ok_cycle", cyc, mon_e.due);
         end
      end
   end

   // Present one request, hold it until it is accepted, then play the slave.
   // Entered and left on a falling edge.
   task automatic run_vec(input vec_t v);
      int   n;
      logic aw_d, w_d;
      sb_t  e;
      req = 1'b1; wr = v.wr; size = v.size; addr = v.addr; wstrb = v.strb;
      wdata = v.wr ? v.data : 32'h0;
      n = 0;
      while (addr_ok !== 1'b1 && n < 40) begin
         @(negedge aclk);
         n++;
      end
      if (addr_ok !== 1'b1) begin
         total++; bad++;
         $display("FAIL accept_timeout: got addr_ok=%b want 1", addr_ok);
         req = 1'b0;
         return;
      end
      e.exp_rdata = v.wr ? model_rdata : v.data;
      e.due = cyc + v.exp_lat;
`ifdef UNCACHE_WBUF_EN
      if (v.wr) e.due = cyc + 1;
`endif
      sb.push_back(e);
      if (!v.wr) model_rdata = v.data;
      @(negedge aclk);
      // Scramble the request inputs to show the payload was captured.
      req = 1'b0; addr = ~addr; wdata = ~wdata; wstrb = ~wstrb; size = ~size;
      if (!v.wr) begin
         for (int i = 0; i <= v.d0; i++) begin
            chk("arvalid", {31'd0, arvalid}, 32'd1);
            chk("araddr", araddr, v.addr);
            chk("arsize", {29'd0, arsize}, {29'd0, v.exp_axsize});
            chk("addr_ok_busy", {31'd0, addr_ok}, 32'd0);
            arready = (i == v.d0);
            @(negedge aclk);
         end
         arready = 1'b0;
         for (int i = 0; i <= v.d1; i++) begin
            chk("rready", {31'd0, rready}, 32'd1);
            chk("arvalid_low", {31'd0, arvalid}, 32'd0);
            rvalid = (i == v.d1);
            axi_rdata = (i == v.d1) ? v.data : 32'h5555_AAAA;
            @(negedge aclk);
         end
         rvalid = 1'b0;
      end else begin
         aw_d = 1'b0; w_d = 1'b0; n = 0;
         while (!(aw_d && w_d) && n < 40) begin
            chk("awvalid", {31'd0, awvalid}, {31'd0, ~aw_d});
            chk("wvalid", {31'd0, wvalid}, {31'd0, ~w_d});
            chk("awaddr", awaddr, v.addr);
            chk("awsize", {29'd0, awsize}, {29'd0, v.exp_axsize});
            chk("axi_wdata", axi_wdata, v.data);
            chk("axi_wstrb", {28'd0, axi_wstrb}, {28'd0, v.strb});
            chk("addr_ok_busy", {31'd0, addr_ok}, 32'd0);
            awready = (n >= v.d0);
            wready  = (n >= v.d1);
            if (awready) aw_d = 1'b1;
            if (wready) w_d = 1'b1;
            @(negedge aclk);
            n++;
         end
         awready = 1'b0; wready = 1'b0;
         for (int i = 0; i <= v.d2; i++) begin
            chk("bready", {31'd0, bready}, 32'd1);
            chk("aw_w_low", {30'd0, awvalid, wvalid}, 32'd0);
            chk("addr_ok_wr_b", {31'd0, addr_ok}, 32'd0);
            bvalid = (i == v.d2);
            @(negedge aclk);
         end
         bvalid = 1'b0;
      end
   endtask

   vec_t rv;

   initial begin
      vt[0] = '{1'b0, 2'd2, 32'h1FD0_F010, 4'h0,    32'hDEAD_BEEF, 0, 0, 0, 3'd2, 3};
      vt[1] = '{1'b1, 2'd1, 32'h1FD0_0100, 4'b0011, 32'h1234_5678, 0, 2, 0, 3'd1, 5};
      vt[2] = '{1'b0, 2'd0, 32'h1FD0_0003, 4'h0,    32'hA5A5_0001, 5, 1, 0, 3'd0, 9};
      vt[3] = '{1'b1, 2'd2, 32'h1FD0_0200, 4'hF,    32'hCAFE_F00D, 3, 0, 2, 3'd2, 8};
      vt[4] = '{1'b1, 2'd0, 32'h1FD0_0301, 4'b0010, 32'h0000_5A00, 1, 1, 0, 3'd0, 4};
      vt[5] = '{1'b0, 2'd1, 32'h1FD0_0402, 4'h0,    32'h0BAD_F00D, 0, 3, 0, 3'd1, 6};

      aresetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0;
      wstrb = 4'd0; wdata = 32'd0; arready = 1'b0; axi_rdata = 32'd0;
      rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      repeat (3) @(negedge aclk);
      chk("reset_outputs", {27'd0, addr_ok, data_ok, arvalid, awvalid, wvalid}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("idle_addr_ok", {31'd0, addr_ok}, 32'd1);
      chk("idle_valids", {28'd0, arvalid, awvalid, wvalid, data_ok}, 32'd0);

      // Transactions run back to back; each request is held across the previous RESP.
      for (int k = 0; k < 6; k++) run_vec(vt[k]);

      // Reset while in RD_R: the read is aborted and outputs clear at once.
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1000_0008;
      while (addr_ok !== 1'b1) @(negedge aclk);
      @(negedge aclk);
      req = 1'b0; arready = 1'b1;
      @(negedge aclk);
      arready = 1'b0;
      chk("rready_pre_reset", {31'd0, rready}, 32'd1);
      aresetn = 1'b0;
      #1;
      chk("rst_mid_ctrl", {26'd0, arvalid, rready, data_ok, addr_ok, awvalid, bready}, 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      chk("rst_mid_araddr", araddr, 32'd0);
      model_rdata = 32'd0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      rv = '{1'b0, 2'd2, 32'h1FD0_0010, 4'h0, 32'h7777_1234, 1, 0, 0, 3'd2, 4};
      run_vec(rv);

      repeat (4) @(negedge aclk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
